// File: rtl/int_pri_enc32_if.sv
`default_nettype none
// ============================================================================
// Module      : int_pri_enc32_if
// Description : Signal bundle between the interrupt sources/CPU control side
//               and the 32-source interrupt priority encoder.
//               slave  : the encoder (takes requests, presents int_req/int_id)
//               master : the CPU/peripheral side driving requests and control
// Ports       : irq[31:0], ie, mask_we, mask_wd[31:0], pend_clr[31:0],
//               int_ack, eoi  (master -> slave)
//               int_req, int_id[4:0], in_service, pending[31:0],
//               mask[31:0]    (slave -> master)
// Revision    : 1.0  initial release
// ============================================================================
interface int_pri_enc32_if;
  logic [31:0] irq;
  logic        ie;
  logic        mask_we;
  logic [31:0] mask_wd;
  logic [31:0] pend_clr;
  logic        int_ack;
  logic        eoi;
  logic        int_req;
  logic [4:0]  int_id;
  logic        in_service;
  logic [31:0] pending;
  logic [31:0] mask;

  modport slave (
    input  irq, ie, mask_we, mask_wd, pend_clr, int_ack, eoi,
    output int_req, int_id, in_service, pending, mask
  );

  modport master (
    output irq, ie, mask_we, mask_wd, pend_clr, int_ack, eoi,
    input  int_req, int_id, in_service, pending, mask
  );
endinterface
`default_nettype wire

// File: rtl/int_pri_enc32.sv
`default_nettype none
// ============================================================================
// Module      : int_pri_enc32
// Description : 32-source interrupt front end. Edge-detects raw requests into
//               a pending register, qualifies them with a software mask and
//               the global IE bit, and presents the lowest-numbered candidate
//               as a 5-bit ID with a req/ack/eoi handshake to the CPU.
// Ports       : clk   - system clock, rising edge
//               clrn  - asynchronous active-low reset
//               bus   - int_pri_enc32_if.slave (requests, mask, handshake)
// Revision    : 1.0  initial release
// ============================================================================
module int_pri_enc32 (
  input  wire               clk,
  input  wire               clrn,
  int_pri_enc32_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] irq_q;
  logic [31:0] pending_q, pending_d;
  logic [31:0] mask_q, mask_d;
  logic [4:0]  id_q, id_d;

  logic [31:0] w_rise;
  logic [31:0] w_cand;
  logic [31:0] w_ack_clr;
  logic [4:0]  w_enc;
  logic        w_ack_take;

  assign w_rise = bus.irq & ~irq_q;
  assign w_cand = pending_q & mask_q;

  // Lowest set index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    w_enc = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (w_cand[i]) w_enc = 5'(i);
    end
  end

  // An ack only counts while a request is actually being presented.
  assign w_ack_take = (state_q == REQ) && bus.int_ack;
  assign w_ack_clr  = w_ack_take ? (32'd1 << id_q) : 32'd0;

  // A fresh rising edge beats any clear landing in the same cycle.
  assign pending_d = w_rise | (pending_q & ~bus.pend_clr & ~w_ack_clr);
  assign mask_d    = bus.mask_we ? bus.mask_wd : mask_q;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (bus.ie && (w_cand != 32'd0)) begin
          state_d = REQ;
          id_d    = w_enc;
        end
      end
      REQ: begin
        // ID stays frozen here; ack outranks a simultaneous withdraw.
        if (bus.int_ack) begin
          state_d = SERVICE;
        end else if (!bus.ie || !w_cand[id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (bus.eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IDLE;
      irq_q     <= 32'd0;
      pending_q <= 32'd0;
      mask_q    <= 32'd0;
      id_q      <= 5'd0;
    end else begin
      state_q   <= state_d;
      irq_q     <= bus.irq;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      id_q      <= id_d;
    end
  end

  assign bus.int_req    = (state_q == REQ);
  assign bus.in_service = (state_q == SERVICE);
  assign bus.int_id     = id_q;
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_int_pri_enc32.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_pri_enc32
// Description : Directed self-checking bench for int_pri_enc32.
// Revision    : 1.0  initial release
// ============================================================================
module tb_int_pri_enc32;

  logic clk;
  logic clrn;
  int   tests;
  int   fails;

  int_pri_enc32_if ifc ();

  int_pri_enc32 dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] b1(input logic v);
    return {31'd0, v};
  endfunction

  function automatic logic [31:0] id32(input logic [4:0] v);
    return {27'd0, v};
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    clrn         = 1'b0;
    ifc.irq      = 32'h0000_0001;
    ifc.ie       = 1'b0;
    ifc.mask_we  = 1'b0;
    ifc.mask_wd  = 32'd0;
    ifc.pend_clr = 32'd0;
    ifc.int_ack  = 1'b0;
    ifc.eoi      = 1'b0;

    // ---------------- reset state and first request ----------------
    #12;
    chk("rst_req",     b1(ifc.int_req),    32'd0);
    chk("rst_svc",     b1(ifc.in_service), 32'd0);
    chk("rst_id",      id32(ifc.int_id),   32'd0);
    chk("rst_pending", ifc.pending,        32'd0);
    chk("rst_mask",    ifc.mask,           32'd0);
    clrn = 1'b1;
    step();
    chk("t1_pend0", ifc.pending, 32'h0000_0001);
    chk("t1_noreq", b1(ifc.int_req), 32'd0);
    ifc.mask_we = 1'b1; ifc.mask_wd = 32'hFFFF_FFFF; ifc.ie = 1'b1;
    step();
    ifc.mask_we = 1'b0;
    chk("t1_mask", ifc.mask, 32'hFFFF_FFFF);
    chk("t1_req_wait", b1(ifc.int_req), 32'd0);
    step();
    chk("t1_req", b1(ifc.int_req), 32'd1);
    chk("t1_id",  id32(ifc.int_id), 32'd0);
    ifc.int_ack = 1'b1;
    step();
    ifc.int_ack = 1'b0;
    chk("t1_ack_req", b1(ifc.int_req), 32'd0);
    chk("t1_ack_svc", b1(ifc.in_service), 32'd1);
    chk("t1_ack_pend", ifc.pending, 32'd0);
    ifc.eoi = 1'b1;
    step();
    ifc.eoi = 1'b0;
    chk("t1_eoi_svc", b1(ifc.in_service), 32'd0);
    step();
    chk("t1_held_norerequest", b1(ifc.int_req), 32'd0);
    ifc.irq = 32'd0;

    // ---------------- simultaneous 5 and 17 ----------------
    ifc.irq = 32'h0002_0020;
    step();
    ifc.irq = 32'd0;
    chk("t2_pend", ifc.pending, 32'h0002_0020);
    step();
    chk("t2_req", b1(ifc.int_req), 32'd1);
    chk("t2_id5", id32(ifc.int_id), 32'd5);
    ifc.int_ack = 1'b1; step(); ifc.int_ack = 1'b0;
    chk("t2_ack_pend", ifc.pending, 32'h0002_0000);
    ifc.eoi = 1'b1; step(); ifc.eoi = 1'b0;
    chk("t2_gap", b1(ifc.int_req), 32'd0);
    step();
    chk("t2_req17", b1(ifc.int_req), 32'd1);
    chk("t2_id17", id32(ifc.int_id), 32'd17);

    // ---------------- frozen ID while in REQ ----------------
    ifc.irq = 32'h0000_0008;
    step();
    ifc.irq = 32'd0;
    chk("t3_pend", ifc.pending, 32'h0002_0008);
    step();
    chk("t3_frozen", id32(ifc.int_id), 32'd17);
    chk("t3_req", b1(ifc.int_req), 32'd1);
    ifc.int_ack = 1'b1; step(); ifc.int_ack = 1'b0;
    ifc.eoi = 1'b1; step(); ifc.eoi = 1'b0;
    step();
    chk("t3_id3", id32(ifc.int_id), 32'd3);
    chk("t3_req3", b1(ifc.int_req), 32'd1);
    ifc.int_ack = 1'b1; step(); ifc.int_ack = 1'b0;
    ifc.eoi = 1'b1; step(); ifc.eoi = 1'b0;
    chk("t3_empty", ifc.pending, 32'd0);

    // ---------------- withdraw on mask ----------------
    ifc.irq = 32'h0000_0200;
    step();
    ifc.irq = 32'd0;
    step();
    chk("t4_id9", id32(ifc.int_id), 32'd9);
    ifc.mask_we = 1'b1; ifc.mask_wd = 32'hFFFF_FDFF;
    step();
    ifc.mask_we = 1'b0;
    chk("t4_still_req", b1(ifc.int_req), 32'd1);
    step();
    chk("t4_withdrawn", b1(ifc.int_req), 32'd0);
    chk("t4_pend9", ifc.pending, 32'h0000_0200);
    ifc.mask_we = 1'b1; ifc.mask_wd = 32'hFFFF_FFFF;
    step();
    ifc.mask_we = 1'b0;
    chk("t4_idle", b1(ifc.int_req), 32'd0);
    step();
    chk("t4_rereq", b1(ifc.int_req), 32'd1);
    chk("t4_reid9", id32(ifc.int_id), 32'd9);
    ifc.int_ack = 1'b1; step(); ifc.int_ack = 1'b0;
    ifc.eoi = 1'b1; step(); ifc.eoi = 1'b0;

    // ---------------- set beats clear; ack beats withdraw ----------------
    ifc.irq = 32'h0000_0010; ifc.pend_clr = 32'h0000_0010;
    step();
    ifc.irq = 32'd0; ifc.pend_clr = 32'd0;
    chk("t5_setwins", ifc.pending, 32'h0000_0010);
    step();
    chk("t5_id4", id32(ifc.int_id), 32'd4);
    ifc.int_ack = 1'b1; ifc.ie = 1'b0;
    step();
    ifc.int_ack = 1'b0; ifc.ie = 1'b1;
    chk("t5_svc", b1(ifc.in_service), 32'd1);
    chk("t5_noreq", b1(ifc.int_req), 32'd0);
    chk("t5_pend", ifc.pending, 32'd0);
    ifc.eoi = 1'b1; step(); ifc.eoi = 1'b0;

    // ---------------- async reset in SERVICE ----------------
    ifc.irq = 32'h0000_1000;
    step();
    step();
    chk("t6_id12", id32(ifc.int_id), 32'd12);
    ifc.int_ack = 1'b1; step(); ifc.int_ack = 1'b0;
    ifc.irq = 32'h0000_1F00;
    step();
    chk("t6_pendF00", ifc.pending, 32'h0000_0F00);
    chk("t6_svc", b1(ifc.in_service), 32'd1);
    #2;
    clrn = 1'b0;
    #1;
    chk("t6_rst_svc",  b1(ifc.in_service), 32'd0);
    chk("t6_rst_req",  b1(ifc.int_req),    32'd0);
    chk("t6_rst_id",   id32(ifc.int_id),   32'd0);
    chk("t6_rst_pend", ifc.pending,        32'd0);
    chk("t6_rst_mask", ifc.mask,           32'd0);
    #2;
    clrn = 1'b1;
    step();
    chk("t6_reset_rise", ifc.pending, 32'h0000_1F00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
